myproject_hls_deadlock_report_arbiter: RTL and testbench

Collects `block` flags from up to NUM_MON per-region HLS deadlock monitors. Each flag must persist THRESH consecutive cycles before it is confirmed. Confirmed events are serialised onto one valid/ready report channel by a round-robin arbiter, which feeds the debug/status path. The block also keeps sticky per-source status and raises a level interrupt, cleared by software via `clr`.

---
 rtl/myproject_hls_deadlock_report_arbiter.sv | 102 ++++++++++
 tb/tb_myproject_hls_deadlock_report_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/myproject_hls_deadlock_report_arbiter.sv
// myproject_hls_deadlock_report_arbiter: debounces HLS deadlock flags and serialises confirmed events round-robin (optional DLK_REPORT_TIMESTAMP_EN adds rpt_ts)
module myproject_hls_deadlock_report_arbiter #(
  parameter int NUM_MON = 4,
  parameter int IDX_W = 2,
  parameter int THRESH = 16,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clr,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [CNT_W-1:0]   rpt_dur,
  output logic [NUM_MON-1:0] pending,
  output logic [NUM_MON-1:0] confirmed,
`ifdef DLK_REPORT_TIMESTAMP_EN
  output logic [CNT_W-1:0]   rpt_ts,
`endif
  output logic               irq
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt [NUM_MON];
  logic [CNT_W-1:0] cnt_nxt [NUM_MON];
  logic [NUM_MON-1:0] conf_nxt, reported;
  logic [IDX_W-1:0] rr, grant;
  logic clr_pend, clear, hs, found, go;
  int j;
`ifdef DLK_REPORT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] ts_cap [NUM_MON];
`endif
  assign pending = confirmed & ~reported;
  assign rpt_valid = state == SEND;
  // Clear qualification, round-robin grant search, counter/confirm next state and FSM transitions
  always_comb begin
    clear = state == IDLE && (clr || clr_pend);
    hs = state == SEND && rpt_ready;
    found = 1'b0;
    grant = '0;
    j = 0;
    for (int k = 0; k < NUM_MON; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_MON) j = j - NUM_MON;
      if (!found && pending[j]) begin
        found = 1'b1;
        grant = IDX_W'(j);
      end
    end
    go = state == IDLE && !clear && found;
    state_nxt = go ? SEND : hs ? IDLE : state;
    for (int i = 0; i < NUM_MON; i++) begin
      cnt_nxt[i] = clear ? '0 : mon_block[i] ? (&cnt[i] ? cnt[i] : cnt[i] + 1'b1) : confirmed[i] ? cnt[i] : '0;
      conf_nxt[i] = !clear && (confirmed[i] || (mon_block[i] && cnt[i] == CNT_W'(THRESH - 1)));
    end
  end
  // State, counters, sticky flags and the held report fields
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '{default: '0};
      confirmed <= '0;
      reported <= '0;
      irq <= 1'b0;
      rr <= '0;
      clr_pend <= 1'b0;
      rpt_idx <= '0;
      rpt_dur <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      confirmed <= conf_nxt;
      irq <= !clear && |confirmed;
      clr_pend <= clear ? 1'b0 : clr_pend | (state == SEND && clr);
      if (clear) reported <= '0;
      else if (hs) reported[rpt_idx] <= 1'b1;
      if (hs) rr <= int'(rpt_idx) == NUM_MON - 1 ? '0 : rpt_idx + 1'b1;
      if (go) begin
        rpt_idx <= grant;
        rpt_dur <= cnt_nxt[grant];
      end
    end
  end
`ifdef DLK_REPORT_TIMESTAMP_EN
  // Free-running timestamp, capture on each source's confirming edge, and report copy
  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
      ts_cap <= '{default: '0};
      rpt_ts <= '0;
    end else begin
      ts <= ts + 1'b1;
      for (int i = 0; i < NUM_MON; i++)
        if (clear) ts_cap[i] <= '0;
        else if (conf_nxt[i] && !confirmed[i]) ts_cap[i] <= ts;
      if (go) rpt_ts <= ts_cap[grant];
    end
  end
`endif
endmodule

// File: tb/tb_myproject_hls_deadlock_report_arbiter.sv
// tb_myproject_hls_deadlock_report_arbiter: directed and random checks against a behavioural model
module tb_myproject_hls_deadlock_report_arbiter;
  localparam int N = 4;
  localparam int TH = 16;
  localparam int CW = 16;
  localparam int MAXC = (1 << CW) - 1;
  logic clock = 0, reset = 1, clr = 0, rpt_ready = 0;
  logic [N-1:0] mon_block = '0;
  logic rpt_valid, irq;
  logic [1:0] rpt_idx;
  logic [CW-1:0] rpt_dur;
  logic [N-1:0] pending, confirmed;
`ifdef DLK_REPORT_TIMESTAMP_EN
  logic [CW-1:0] rpt_ts;
`endif
  int errors = 0, checks = 0;

  myproject_hls_deadlock_report_arbiter dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .clr(clr),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx), .rpt_dur(rpt_dur),
    .pending(pending), .confirmed(confirmed),
`ifdef DLK_REPORT_TIMESTAMP_EN
    .rpt_ts(rpt_ts),
`endif
    .irq(irq));

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-source blocked-cycle counts, sticky flags and one report slot
  int m_cnt[N], m_tscap[N];
  bit m_conf[N], m_rep[N];
  bit m_busy, m_clrp, m_irq;
  int m_idx, m_dur, m_rr, m_ts, m_rts, m_hs;

  always @(posedge clock) begin
    int nc[N];
    bit nconf[N];
    bit clear, ob, anyc;
    int g, jj;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_conf[i] = 0; m_rep[i] = 0; m_tscap[i] = 0; end
      m_busy = 0; m_clrp = 0; m_irq = 0; m_idx = 0; m_dur = 0; m_rr = 0; m_ts = 0; m_rts = 0;
    end else begin
      ob = m_busy;
      clear = !ob && (clr || m_clrp);
      anyc = 0;
      for (int i = 0; i < N; i++) begin
        anyc |= m_conf[i];
        nc[i] = clear ? 0 : mon_block[i] ? (m_cnt[i] < MAXC ? m_cnt[i] + 1 : MAXC) : (m_conf[i] ? m_cnt[i] : 0);
        nconf[i] = !clear && (m_conf[i] || (mon_block[i] && m_cnt[i] + 1 == TH));
      end
      g = -1;
      if (!ob && !clear)
        for (int k = 0; k < N; k++) begin
          jj = (m_rr + k) % N;
          if (g < 0 && m_conf[jj] && !m_rep[jj]) g = jj;
        end
      if (g >= 0) begin
        m_busy = 1; m_idx = g; m_dur = nc[g]; m_rts = m_tscap[g];
      end else if (ob && rpt_ready) begin
        m_rep[m_idx] = 1; m_rr = (m_idx + 1) % N; m_busy = 0; m_hs++;
      end
      for (int i = 0; i < N; i++) begin
        if (clear) begin m_rep[i] = 0; m_tscap[i] = 0; end
        else if (nconf[i] && !m_conf[i]) m_tscap[i] = m_ts;
        m_cnt[i] = nc[i];
        m_conf[i] = nconf[i];
      end
      m_clrp = clear ? 0 : (m_clrp || (ob && clr));
      m_irq = !clear && anyc;
      m_ts = (m_ts + 1) % (MAXC + 1);
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(posedge clock) begin
    logic [N-1:0] ec, ep;
    #1;
    for (int i = 0; i < N; i++) begin ec[i] = m_conf[i]; ep[i] = m_conf[i] && !m_rep[i]; end
    chk("rpt_valid", rpt_valid, m_busy);
    chk("confirmed", confirmed, ec);
    chk("pending", pending, ep);
    chk("irq", irq, m_irq);
    if (m_busy) begin
      chk("rpt_idx", rpt_idx, m_idx);
      chk("rpt_dur", rpt_dur, m_dur);
`ifdef DLK_REPORT_TIMESTAMP_EN
      chk("rpt_ts", rpt_ts, m_rts);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1; mon_block = '0; clr = 0; rpt_ready = 0;
    step(1);
    reset = 0;
  endtask

  initial begin
    int hs0;
    step(2);
    chk("reset_valid", rpt_valid, 0);
    chk("reset_confirmed", confirmed, 0);
    chk("reset_irq", irq, 0);
    reset = 0;
    // 15 cycles is one short of confirmation; repeat to show the count restarted
    repeat (2) begin
      mon_block = 4'b0010; step(15);
      mon_block = 4'b0000; step(3);
    end
    chk("short_confirmed", confirmed, 0);
    chk("short_valid", rpt_valid, 0);
    // single source held high with ready
    hs0 = m_hs;
    rpt_ready = 1; mon_block = 4'b0100; step(16);
    chk("s2_conf_edge16", confirmed, 4'b0100);
    chk("s2_valid_edge16", rpt_valid, 0);
    step(1);
    chk("s2_valid_edge17", rpt_valid, 1);
    chk("s2_idx", rpt_idx, 2);
    chk("s2_dur", rpt_dur, 17);
    chk("s2_irq", irq, 1);
    step(10);
    chk("s2_one_report", m_hs - hs0, 1);
    chk("s2_no_repeat", rpt_valid, 0);
    // two simultaneous confirmations from rr=0
    do_reset();
    rpt_ready = 1; mon_block = 4'b1001; step(17);
    chk("pair_first_idx", rpt_idx, 0);
    chk("pair_first_valid", rpt_valid, 1);
    step(1);
    chk("pair_gap", rpt_valid, 0);
    step(1);
    chk("pair_second_idx", rpt_idx, 3);
    chk("pair_second_dur", rpt_dur, 19);
    step(1);
    chk("pair_pending_done", pending, 0);
    // back-pressure holds the report while counting continues
    do_reset();
    mon_block = 4'b0010; step(17);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", rpt_valid, 1);
      chk("hold_idx", rpt_idx, 1);
      chk("hold_dur", rpt_dur, 17);
      step(1);
    end
    rpt_ready = 1; step(1);
    chk("hold_released", rpt_valid, 0);
    chk("hold_pending", pending, 0);
    // clr during SEND is deferred until after the handshake
    do_reset();
    mon_block = 4'b0100; step(17);
    clr = 1; step(1); clr = 0; step(3);
    chk("clr_still_valid", rpt_valid, 1);
    hs0 = m_hs;
    rpt_ready = 1; mon_block = 4'b0000; step(1);
    chk("clr_hs_valid", rpt_valid, 0);
    chk("clr_hs_conf", confirmed, 4'b0100);
    step(1);
    chk("clr_applied_conf", confirmed, 0);
    chk("clr_applied_irq", irq, 0);
    step(5);
    chk("clr_no_more", m_hs - hs0, 1);
    // randomised traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(19) == 0) mon_block[i] = ~mon_block[i];
      rpt_ready = $urandom_range(2) != 0;
      clr = $urandom_range(60) == 0;
      reset = $urandom_range(700) == 0;
      step(1);
    end
    reset = 0; clr = 0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
